// File: rtl/dmem_port_arbiter.sv
// Two-master arbiter for the single data-RAM port: CPU (m0) owns the port by default,
// a secondary master (m1) gets bounded bursts plus a guaranteed grant after a starvation limit.
module dmem_port_arbiter #(
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned STARVE_LIM = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [3:0]        m0_wstrb,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_stall,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [3:0]        m1_wstrb,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_gnt,
  output logic [31:0]       ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  output logic [3:0]        ram_wstrb,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       rdata,
  output logic [CNT_W-1:0]  m1_xfer_cnt,
  output logic [CNT_W-1:0]  m0_stall_cnt
);

  localparam int unsigned BURST_W  = (MAX_BURST > 1)  ? $clog2(MAX_BURST)  : 1;
  localparam int unsigned STARVE_W = (STARVE_LIM > 1) ? $clog2(STARVE_LIM) : 1;
  localparam logic [BURST_W-1:0]  BURST_LAST  = BURST_W'(MAX_BURST - 1);
  localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_W'(STARVE_LIM - 1);

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [BURST_W-1:0]   burst_cnt;
  logic [STARVE_W-1:0]  starve_cnt;
  logic                 enter_m1;
  logic                 m1_xfer;
  logic                 owner_req;
  logic                 owner_we;
  logic [3:0]           owner_wstrb;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= OWN_M0;
    else     state <= state_nxt;
  end

  // Next-state and grant decode; grants depend on state only
  always_comb begin
    state_nxt = state;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    unique case (state)
      OWN_M0: begin
        m0_gnt = 1'b1;
        if (m1_req && (!m0_req || (starve_cnt == STARVE_LAST))) state_nxt = OWN_M1;
      end
      OWN_M1: begin
        m1_gnt = 1'b1;
        // m1_req high here means this cycle is an m1 transfer
        if (!m1_req || (m0_req && (burst_cnt == BURST_LAST))) state_nxt = OWN_M0;
      end
      default: state_nxt = OWN_M0;
    endcase
  end

  assign enter_m1 = (state == OWN_M0) && (state_nxt == OWN_M1);
  assign m1_xfer  = m1_gnt & m1_req;
  assign m0_stall = m0_req & ~m0_gnt;
  assign rdata    = ram_rdata;

  // RAM port mux from the current owner
  always_comb begin
    owner_req   = m0_req;
    owner_we    = m0_we;
    owner_wstrb = m0_wstrb;
    ram_addr    = m0_addr;
    ram_wdata   = m0_wdata;
    if (state == OWN_M1) begin
      owner_req   = m1_req;
      owner_we    = m1_we;
      owner_wstrb = m1_wstrb;
      ram_addr    = m1_addr;
      ram_wdata   = m1_wdata;
    end
    ram_we    = owner_req & owner_we & ~rst;
    ram_wstrb = ram_we ? owner_wstrb : 4'h0;
  end

  // Cycles m1 has been kept waiting behind a busy m0
  always_ff @(posedge clk) begin
    if (rst)                      starve_cnt <= '0;
    else if (enter_m1 || !m1_req) starve_cnt <= '0;
    else if (!m1_gnt)             starve_cnt <= starve_cnt + STARVE_W'(1);
  end

  // m1 transfers in the current tenure, saturating at the last burst slot
  always_ff @(posedge clk) begin
    if (rst)                                    burst_cnt <= '0;
    else if (enter_m1)                          burst_cnt <= '0;
    else if (m1_xfer && burst_cnt != BURST_LAST) burst_cnt <= burst_cnt + BURST_W'(1);
  end

  // Statistics: wrapping transfer count, saturating stall count
  always_ff @(posedge clk) begin
    if (rst) begin
      m1_xfer_cnt  <= '0;
      m0_stall_cnt <= '0;
    end else begin
      if (m1_xfer)                     m1_xfer_cnt  <= m1_xfer_cnt + CNT_W'(1);
      if (m0_stall && !(&m0_stall_cnt)) m0_stall_cnt <= m0_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: drivers queue expected transactions, a negedge
// monitor pops them on each grant and checks RAM traffic, read data, counters and latency bounds.
module tb_dmem_port_arbiter;

  localparam int unsigned MAX_BURST  = 4;
  localparam int unsigned STARVE_LIM = 8;
  localparam int unsigned CNT_W      = 16;
  localparam int          WAIT_LIMIT = 200;

  typedef struct packed {
    logic        we;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  logic m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic m0_gnt, m0_stall, m1_gnt;
  logic [31:0] ram_addr, ram_wdata, ram_rdata, rdata;
  logic ram_we;
  logic [3:0] ram_wstrb;
  logic [CNT_W-1:0] m1_xfer_cnt, m0_stall_cnt;

  int checks = 0;
  int failures = 0;

  dmem_port_arbiter #(.MAX_BURST(MAX_BURST), .STARVE_LIM(STARVE_LIM), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_stall(m0_stall),
    .m1_req(m1_req), .m1_we(m1_we), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_wstrb(ram_wstrb),
    .ram_rdata(ram_rdata), .rdata(rdata),
    .m1_xfer_cnt(m1_xfer_cnt), .m0_stall_cnt(m0_stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    logic [7:0] b;
    b = 8'(i);
    return (i == 8) ? 32'h1234_5678 : {b, 8'hC3, b ^ 8'h5A, 8'h3C};
  endfunction

  // Data RAM: asynchronous read, byte-strobed synchronous write
  logic [31:0] ram [0:255];
  bit ram_ready = 1'b0;
  assign ram_rdata = ram[ram_addr[9:2]];
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
      ram_ready <= 1'b1;
    end else if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_wstrb[b]) ram[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard state
  txn_t q0[$];
  txn_t q1[$];
  logic [31:0] ref_mem [0:255];
  bit ref_ready = 1'b0;
  int exp_xfer = 0;
  int exp_stall = 0;
  int m0_wait = 0;
  int m1_wait = 0;
  bit prev_ok = 1'b0;
  bit prev_m1_req = 1'b0;
  bit prev_m1_idle = 1'b0;
  logic [31:0] last_m1_rdata = '0;

  task automatic check_xfer(input string who, input txn_t t);
    logic [7:0] idx;
    idx = t.addr[9:2];
    chk({who, "_addr"}, ram_addr, t.addr);
    chk({who, "_we"}, 32'(ram_we), 32'(t.we));
    chk({who, "_wstrb"}, 32'(ram_wstrb), t.we ? 32'(t.strb) : 32'd0);
    chk({who, "_wdata"}, ram_wdata, t.wdata);
    if (t.we) begin
      for (int b = 0; b < 4; b++)
        if (t.strb[b]) ref_mem[idx][8*b +: 8] = t.wdata[8*b +: 8];
    end else begin
      chk({who, "_rdata"}, rdata, ref_mem[idx]);
    end
  endtask

  // Monitor: samples mid-cycle, compares the transfer that completes at the next edge
  always @(negedge clk) begin
    bit x0, x1;
    txn_t t;
    if (!ref_ready) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      ref_ready = 1'b1;
    end
    if (rst) begin
      exp_xfer = 0; exp_stall = 0; m0_wait = 0; m1_wait = 0; prev_ok = 1'b0;
    end else begin
      chk("m1_xfer_cnt", 32'(m1_xfer_cnt), 32'(exp_xfer));
      chk("m0_stall_cnt", 32'(m0_stall_cnt), 32'(exp_stall));
      chk("one_owner", 32'(m0_gnt ^ m1_gnt), 32'd1);
      chk("m0_stall", 32'(m0_stall), 32'(m0_req & ~m0_gnt));
      if (prev_ok && !prev_m1_req) chk("park_m0", 32'(m0_gnt), 32'd1);
      if (prev_ok && prev_m1_idle) chk("m1_idle_latency", 32'(m1_gnt), 32'd1);
      x0 = m0_gnt & m0_req;
      x1 = m1_gnt & m1_req;
      if (x0) begin
        if (q0.size() == 0) chk("m0_unexpected_xfer", 32'd1, 32'd0);
        else begin t = q0.pop_front(); check_xfer("m0", t); end
      end
      if (x1) begin
        if (q1.size() == 0) chk("m1_unexpected_xfer", 32'd1, 32'd0);
        else begin
          t = q1.pop_front(); check_xfer("m1", t);
          if (!t.we) last_m1_rdata = rdata;
        end
      end
      if (!x0 && !x1) begin
        chk("idle_ram_we", 32'(ram_we), 32'd0);
        chk("idle_ram_wstrb", 32'(ram_wstrb), 32'd0);
      end
      if (m1_req && !m1_gnt) m1_wait++;
      else begin
        if (x1) chk("m1_starve_bound", 32'(m1_wait <= int'(STARVE_LIM)), 32'd1);
        m1_wait = 0;
      end
      if (m0_req && !m0_gnt) m0_wait++;
      else begin
        if (x0) chk("m0_latency_bound", 32'(m0_wait <= int'(MAX_BURST) + 1), 32'd1);
        m0_wait = 0;
      end
      if (x1) exp_xfer = (exp_xfer + 1) % (1 << CNT_W);
      if (m0_req && !m0_gnt && exp_stall < (1 << CNT_W) - 1) exp_stall++;
      prev_ok = 1'b1;
      prev_m1_req = m1_req;
      prev_m1_idle = m1_req & ~m1_gnt & ~m0_req;
    end
  end

  function automatic txn_t mk(input logic we, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.we = we; t.strb = s; t.addr = a; t.wdata = d;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    return mk(1'($urandom), 4'($urandom), {22'd0, 8'($urandom), 2'b00}, $urandom);
  endfunction

  // Issue one level-held request (called just after a posedge); waits = cycles before grant
  task automatic issue(input bit which, input txn_t t, output int waits);
    bit g;
    if (which) begin
      m1_req = 1'b1; m1_we = t.we; m1_wstrb = t.strb; m1_addr = t.addr; m1_wdata = t.wdata;
      q1.push_back(t);
    end else begin
      m0_req = 1'b1; m0_we = t.we; m0_wstrb = t.strb; m0_addr = t.addr; m0_wdata = t.wdata;
      q0.push_back(t);
    end
    waits = 0;
    g = 1'b0;
    while (!g) begin
      @(negedge clk);
      g = which ? m1_gnt : m0_gnt;
      @(posedge clk); #1;
      if (!g) begin
        waits++;
        if (waits >= WAIT_LIMIT) begin
          chk(which ? "m1_grant_timeout" : "m0_grant_timeout", 32'(waits), 32'd0);
          g = 1'b1;
        end
      end
    end
    if (which) m1_req = 1'b0; else m0_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  int w, w0, n, m0_max;
  int t4w [6];

  initial begin
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_wstrb = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_wstrb = 0; m1_addr = 0; m1_wdata = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_m0_gnt", 32'(m0_gnt), 32'd1);
    chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_wstrb", 32'(ram_wstrb), 32'd0);
    chk("rst_m0_stall", 32'(m0_stall), 32'd0);
    chk("rst_cnts", 32'(m1_xfer_cnt) | 32'(m0_stall_cnt), 32'd0);
    @(posedge clk); #1;

    // 1: uncontended CPU writes complete with no stall
    issue(0, mk(1'b1, 4'hF, 32'h10, 32'hA5A5_A5A5), w); chk("t1_wait0", 32'(w), 32'd0);
    issue(0, mk(1'b1, 4'hF, 32'h14, 32'hA5A5_A5A5), w); chk("t1_wait1", 32'(w), 32'd0);
    @(negedge clk);
    chk("t1_stall_cnt", 32'(m0_stall_cnt), 32'd0);
    chk("t1_ram_10", ram[4], 32'hA5A5_A5A5);
    chk("t1_ram_14", ram[5], 32'hA5A5_A5A5);
    @(posedge clk); #1;

    // 2: m1 alone, one-cycle grant latency then back-to-back
    pulse_rst();
    for (int k = 0; k < 6; k++) begin
      issue(1, mk(1'b1, 4'hF, 32'h40 + 32'(4*k), 32'hD000_0000 | 32'(k)), w);
      chk("t2_m1_wait", 32'(w), (k == 0) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    chk("t2_xfer_cnt", 32'(m1_xfer_cnt), 32'd6);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_park", 32'(m0_gnt), 32'd1);
    @(posedge clk); #1;

    // 3: m0 arrives at m1's 2nd transfer; m1 yields after its 4th
    pulse_rst();
    fork
      for (int k = 0; k < 10; k++)
        issue(1, mk(1'b1, 4'hF, 32'h80 + 32'(4*k), 32'hB000_0000 | 32'(k)), w);
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (!m1_gnt && n < 50);
        @(posedge clk); #1;
        issue(0, mk(1'b1, 4'hF, 32'h200, 32'hCAFE_0003), w0);
      end
    join
    chk("t3_m0_wait", 32'(w0), 32'(MAX_BURST - 2 + 1));
    @(negedge clk);
    chk("t3_stall_cnt", 32'(m0_stall_cnt), 32'(w0));
    chk("t3_xfer_cnt", 32'(m1_xfer_cnt), 32'd10);
    @(posedge clk); #1;

    // 4: m0 continuously busy, m1 forced in after the starvation limit
    pulse_rst();
    m0_max = 0;
    fork
      for (int k = 0; k < 24; k++) begin
        int wm;
        issue(0, mk(1'b0, 4'h0, {22'd0, 8'($urandom), 2'b00}, 32'h0), wm);
        if (wm > m0_max) m0_max = wm;
      end
      for (int k = 0; k < 6; k++) begin
        int wk;
        issue(1, mk(1'b0, 4'h0, {22'd0, 8'($urandom), 2'b00}, 32'h0), wk);
        t4w[k] = wk;
      end
    join
    for (int k = 0; k < 6; k++)
      chk("t4_m1_wait", 32'(t4w[k]), (k == 0 || k == 4) ? 32'(STARVE_LIM) : 32'd0);
    chk("t4_m0_max_wait", 32'(m0_max), 32'(MAX_BURST));
    idle(2);

    // 5: reset lands on the 3rd transfer of an m1 write burst
    pulse_rst();
    m1_req = 1'b1; m1_we = 1'b1; m1_wstrb = 4'hF; m1_addr = 32'h100; m1_wdata = 32'h5555_0001;
    q1.push_back(mk(1'b1, 4'hF, 32'h100, 32'h5555_0001));
    @(posedge clk); #1;
    @(posedge clk); #1;
    m1_addr = 32'h104; m1_wdata = 32'h5555_0002;
    q1.push_back(mk(1'b1, 4'hF, 32'h104, 32'h5555_0002));
    @(posedge clk); #1;
    m1_addr = 32'h108; m1_wdata = 32'h5555_0003;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_ram_we", 32'(ram_we), 32'd0);
    chk("t5_rst_ram_wstrb", 32'(ram_wstrb), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    chk("t5_m0_gnt", 32'(m0_gnt), 32'd1);
    chk("t5_m1_gnt", 32'(m1_gnt), 32'd0);
    chk("t5_xfer_cnt", 32'(m1_xfer_cnt), 32'd0);
    chk("t5_stall_cnt", 32'(m0_stall_cnt), 32'd0);
    chk("t5_ram_108", ram[66], init_val(66));
    chk("t5_ram_104", ram[65], 32'h5555_0002);
    q0.delete(); q1.delete();
    @(posedge clk); #1;

    // 6: m1 read with m0 idle
    issue(1, mk(1'b0, 4'h0, 32'h20, 32'h0), w);
    chk("t6_m1_wait", 32'(w), 32'd1);
    chk("t6_rdata", last_m1_rdata, 32'h1234_5678);
    chk("t6_ram_20", ram[8], 32'h1234_5678);

    // Random contention
    pulse_rst();
    fork
      for (int k = 0; k < 60; k++) begin
        int wr;
        idle($urandom_range(0, 2));
        issue(0, rand_txn(), wr);
      end
      for (int k = 0; k < 60; k++) begin
        int wr;
        idle($urandom_range(0, 3));
        issue(1, rand_txn(), wr);
      end
    join
    idle(2);
    for (int i = 0; i < 256; i++) chk("final_ram", ram[i], ref_mem[i]);
    chk("final_q_empty", 32'(q0.size() + q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
